// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI burst RAM: command opcodes and payload-width helper.
package spi_ram_pkg;

    localparam logic [1:0] OP_SET_WR = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SET_RD = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    // Payload field must carry either a full address or a full data word.
    function automatic int pl_width(input int addr_w, input int data_w);
        if (addr_w > data_w) begin
            return addr_w;
        end else begin
            return data_w;
        end
    endfunction

endpackage

// File: rtl/spi_ram_ptr.sv
// Range-checked address pointer that wraps at MEM_DEPTH; err_o pulses when a load is rejected.
module spi_ram_ptr #(
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] val_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              err_o
);

    // One extra bit so a depth of exactly 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(MEM_DEPTH - 1);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic              err_q;
    logic              err_d;

    // Next pointer: load with range check, otherwise optional wrapping increment.
    always_comb begin
        ptr_d = ptr_q;
        err_d = 1'b0;
        if (load_i) begin
            if ({1'b0, val_i} < DEPTH_L) begin
                ptr_d = val_i;
            end else begin
                err_d = 1'b1;
            end
        end else if (inc_i && (AUTO_INC != 0)) begin
            if (ptr_q == LAST_L) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + ADDR_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer and error-pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    assign ptr_o = ptr_q;
    assign err_o = err_q;

endmodule

// File: rtl/spi_burst_ram.sv
// Command-decoded single-port RAM behind the SPI slave with auto-incrementing burst pointers.
// Optional per-word even parity and parity_err output: define SPI_BURST_RAM_PARITY_EN.
module spi_burst_ram
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1,
    localparam int PL_W     = pl_width(ADDR_W, DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PL_W+1:0]   din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              addr_err,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr
`ifdef SPI_BURST_RAM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

`ifdef SPI_BURST_RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;

    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [1:0]        op_s;
    logic              set_wr_s;
    logic              write_s;
    logic              set_rd_s;
    logic              read_s;
    logic [ADDR_W-1:0] wr_ptr_s;
    logic [ADDR_W-1:0] rd_ptr_s;
    logic              wr_err_s;
    logic              rd_err_s;
    logic [MEM_W-1:0]  wr_word_s;
    logic [MEM_W-1:0]  rd_word_s;
    logic [MEM_W-1:0]  mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;
    logic              tx_q;
    logic              tx_d;
    logic              perr_q;
    logic              perr_d;

    assign op_s     = din[PL_W+1:PL_W];
    assign set_wr_s = rx_valid && (op_s == OP_SET_WR);
    assign write_s  = rx_valid && (op_s == OP_WRITE);
    assign set_rd_s = rx_valid && (op_s == OP_SET_RD);
    assign read_s   = rx_valid && (op_s == OP_READ);

    spi_ram_ptr #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .AUTO_INC(AUTO_INC)) u_wr_ptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (set_wr_s),
        .inc_i  (write_s),
        .val_i  (din[ADDR_W-1:0]),
        .ptr_o  (wr_ptr_s),
        .err_o  (wr_err_s)
    );

    spi_ram_ptr #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .AUTO_INC(AUTO_INC)) u_rd_ptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (set_rd_s),
        .inc_i  (read_s),
        .val_i  (din[ADDR_W-1:0]),
        .ptr_o  (rd_ptr_s),
        .err_o  (rd_err_s)
    );

`ifdef SPI_BURST_RAM_PARITY_EN
    assign wr_word_s = {even_par(din[DATA_W-1:0]), din[DATA_W-1:0]};
`else
    assign wr_word_s = din[DATA_W-1:0];
`endif
    assign rd_word_s = mem_q[rd_ptr_s];

    // Storage write; gated by rst_n so a reset cycle never commits a partial write.
    always_ff @(posedge clk) begin
        if (rst_n && write_s) begin
            mem_q[wr_ptr_s] <= wr_word_s;
        end
    end

    // Read-data path: new dout and tx pulse on the edge that samples READ.
    always_comb begin
        dout_d = dout_q;
        tx_d   = 1'b0;
        perr_d = 1'b0;
        if (read_s) begin
            dout_d = rd_word_s[DATA_W-1:0];
            tx_d   = 1'b1;
`ifdef SPI_BURST_RAM_PARITY_EN
            perr_d = rd_word_s[DATA_W] ^ even_par(rd_word_s[DATA_W-1:0]);
`endif
        end else begin
            dout_d = dout_q;
            tx_d   = 1'b0;
            perr_d = 1'b0;
        end
    end

    // Read-data output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= '0;
            tx_q   <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            dout_q <= dout_d;
            tx_q   <= tx_d;
            perr_q <= perr_d;
        end
    end

    assign dout     = dout_q;
    assign tx_valid = tx_q;
    assign addr_err = wr_err_s | rd_err_s;
    assign wr_ptr   = wr_ptr_s;
    assign rd_ptr   = rd_ptr_s;
`ifdef SPI_BURST_RAM_PARITY_EN
    assign parity_err = perr_q;
`else
    logic unused_perr_s;
    assign unused_perr_s = perr_q;
`endif

endmodule

// File: doc/spi_burst_ram.md
Name: spi_burst_ram

Overview:
- Parametrised single-port synchronous RAM behind the SPI slave.
- Decodes 2-bit command-tagged words from the SPI slave: set write address, write data, set read address, read data.
- Generalises the previous RAM: data width is independent of address width, depth need not be a power of two, and read/write pointers auto-increment for bursts.
- Reports out-of-range addresses and read-data framing to the SPI slave TX path.

Parameters:
- ADDR_W, 8, address width in bits.
- DATA_W, 8, stored word width in bits.
- MEM_DEPTH, 256, number of words; must satisfy 1 <= MEM_DEPTH <= 2**ADDR_W.
- AUTO_INC, 1, 1 = pointer increments after each data write/read; 0 = pointers hold.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- din  input  PL_W+2  command word: [PL_W+1:PL_W] opcode, [PL_W-1:0] payload; PL_W = max(ADDR_W, DATA_W).
- rx_valid  input  1  din valid this cycle; one command per asserted cycle.
- dout  output  DATA_W  read data.
- tx_valid  output  1  one-cycle pulse: dout is new.
- addr_err  output  1  one-cycle pulse: address command rejected.
- wr_ptr  output  ADDR_W  current write pointer (debug/status).
- rd_ptr  output  ADDR_W  current read pointer (debug/status).

Behaviour:
- Reset (rst_n=0 at a clk edge): dout=0, tx_valid=0, addr_err=0, wr_ptr=0, rd_ptr=0. Memory contents are not reset. Reset wins over rx_valid in the same cycle.
- Pulse outputs: tx_valid and addr_err default to 0 on every edge unless set by the current command.
- rx_valid=0: no state change; dout holds its value.
- Opcode 00, SET_WR:
  - If din[ADDR_W-1:0] < MEM_DEPTH, wr_ptr <= that value.
  - Otherwise wr_ptr is unchanged and addr_err=1 for one cycle.
- Opcode 01, WRITE: mem[wr_ptr] <= din[DATA_W-1:0]. If AUTO_INC, wr_ptr <= (wr_ptr==MEM_DEPTH-1) ? 0 : wr_ptr+1.
- Opcode 10, SET_RD: same range check and addr_err rule as SET_WR, applied to rd_ptr.
- Opcode 11, READ:
  - dout <= mem[rd_ptr] and tx_valid=1, both on the same edge that samples the command (1-cycle latency).
  - If AUTO_INC, rd_ptr wraps exactly as wr_ptr does.
- Consecutive-cycle READs: tx_valid stays high across cycles, with a new dout each cycle.
- Read and write to the same address in consecutive cycles: the READ returns the data written by the preceding WRITE.
- Payload bits above DATA_W (WRITE) or above ADDR_W (SET_*) are ignored.
- Mid-burst reset: pointers return to 0; no partial write occurs.

Optional Feature:
- Macro: SPI_BURST_RAM_PARITY_EN.
- With the macro defined:
  - Each word stores an extra even-parity bit computed on WRITE.
  - New output port parity_err (1 bit): on READ it is set with tx_valid when the recomputed parity mismatches; otherwise 0.
  - Reset value of parity_err is 0.
- Without the macro: no parity storage and no parity_err port.

Decomposition:
- Shared package spi_ram_pkg holds:
  - opcode constants OP_SET_WR=2'b00, OP_WRITE=2'b01, OP_SET_RD=2'b10, OP_READ=2'b11;
  - the function computing PL_W from ADDR_W/DATA_W.
- One natural sub-module, spi_ram_ptr: a wrap-at-MEM_DEPTH pointer with load, range check, increment and err outputs. It is instantiated twice, once for write and once for read.
- The storage array stays inline.

Test Plan:
- Reset, then SET_WR 0x10, WRITE 0xA5, SET_RD 0x10, READ -> dout=0xA5, tx_valid high for exactly 1 cycle; wr_ptr=0x11, rd_ptr=0x11.
- MEM_DEPTH=200: SET_WR 0xC7, WRITE 0x11, WRITE 0x22 -> mem[199]=0x11, mem[0]=0x22, wr_ptr=1.
- MEM_DEPTH=200: SET_RD 0xC8 -> addr_err 1-cycle pulse, rd_ptr unchanged.
- Burst of 4 WRITEs 1,2,3,4 from address 0, then 4 back-to-back READs -> tx_valid high for 4 cycles, dout sequence 1,2,3,4.
- AUTO_INC=0: two WRITEs 0x33, 0x44 -> mem[wr_ptr]=0x44, wr_ptr unchanged.
- rst_n low in the cycle after a SET_WR during a burst -> all outputs and pointers 0; next READ returns mem[0].
- SPI_BURST_RAM_PARITY_EN: force-flip a stored bit via hierarchical access, then READ -> parity_err=1 coincident with tx_valid.
